// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master-side FSM states.
package axi_lite_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } m_state_t;

endpackage : axi_lite_pkg

// File: rtl/simple2axi_master.sv
// AXI4-Lite initiator: turns one single-beat command at a time into an
// AXI4-Lite read or write, reports BRESP/RRESP and aborts hung transfers.
module simple2axi_master
    import axi_lite_pkg::*;
#(
    parameter int          TIMEOUT       = 256,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    // AXI4-Lite write address
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    // AXI4-Lite write data
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    // AXI4-Lite write response
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    // AXI4-Lite read address
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    // AXI4-Lite read data
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp
);

    // A zero TIMEOUT disables the counter; keep it one bit wide so it still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    m_state_t           state_q,   state_d;
    logic [31:0]        addr_q,    addr_d;
    logic [31:0]        wdata_q,   wdata_d;
    logic [3:0]         wstrb_q,   wstrb_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic [1:0]         resp_q,    resp_d;
    logic               timeout_q, timeout_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q,  wvalid_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q,  w_done_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic busy, timeout_hit, to_fire;

    // State and datapath registers; reset drops every valid immediately.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= AXI_OKAY;
            timeout_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, handshake tracking, response capture and timeout abort.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;

        aw_hs  = awvalid_q & m_awready;
        w_hs   = wvalid_q & m_wready;
        b_hs   = (state_q == WR_RESP) & m_bvalid;
        ar_hs  = (state_q == RD_REQ) & m_arready;
        r_hs   = (state_q == RD_RESP) & m_rvalid;
        any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

        busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
               (state_q == RD_REQ) || (state_q == RD_RESP);
        // Fires once the count would reach TIMEOUT-1; >= keeps it armed when a
        // partial write handshake deferred it by a cycle.
        timeout_hit = (TIMEOUT > 0) && busy && ((int'(cnt_q) + 1) >= (TIMEOUT - 1));
        // A handshake in the same cycle always wins over the timeout.
        to_fire = timeout_hit & ~any_hs;

        if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    resp_d  = m_bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rdata_d = m_rdata;
                    resp_d  = m_rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: leaving the busy states drops every request valid and ready.
        if (to_fire) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            resp_d    = AXI_SLVERR;
            timeout_d = 1'b1;
            rdata_d   = ((state_q == RD_REQ) || (state_q == RD_RESP)) ? TIMEOUT_RDATA : 32'h0;
            state_d   = RSP;
        end
    end

    // Handshake strobes decode from state or come straight from flops.
    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RSP);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = (state_q == WR_RESP);
    assign m_arvalid = (state_q == RD_REQ);
    assign m_araddr  = addr_q;
    assign m_rready  = (state_q == RD_RESP);

endmodule : simple2axi_master

// File: tb/tb_simple2axi_master.sv
// Self-checking bench for simple2axi_master: directed cases plus randomized
// transactions against a transaction-level latency/response model.
module tb_simple2axi_master;

    localparam int          TO     = 16;
    localparam logic [31:0] TO_RD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    int n_asserts = 0;
    int n_fail    = 0;

    simple2axi_master #(
        .TIMEOUT       (TO),
        .TIMEOUT_RDATA (TO_RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_awaddr    (m_awaddr),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_bresp     (m_bresp),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_araddr    (m_araddr),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed hang required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h0;
        m_rresp   = 2'b00;
    endtask

    // One command from accept to response handshake. Iteration k is the
    // negedge before posedge k; the command is accepted at posedge 0.
    // Slave delays count cycles the valid has been seen before ready rises.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int ar_dly, input int rsp_dly, input logic [1:0] resp,
                           input logic [31:0] rdata, input int hold, input int rst_at);
        int          e_last, e_rsp, e_aw, e_w;
        bit          e_to;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        int awc = 0, wc = 0, arc = 0, bc = 0, rc = 0;
        int aw_at = -1, w_at = -1, ar_at = -1, b_at = -1, r_at = -1, rsp_at = -1;
        int n_b = 0, n_r = 0;
        bit done = 1'b0;

        // Reference: last handshake cycle from the slave delays; anything past
        // TO-1 is cut off and answered as a timeout at accept+TO.
        e_aw   = 1 + aw_dly;
        e_w    = 1 + w_dly;
        e_last = wr ? (((e_aw > e_w) ? e_aw : e_w) + 1 + rsp_dly) : (1 + ar_dly + 1 + rsp_dly);
        e_to   = (e_last > TO - 1);
        e_rsp  = e_to ? TO : e_last + 1;
        e_rdata = e_to ? (wr ? 32'h0 : TO_RD) : (wr ? 32'h0 : rdata);
        e_resp  = e_to ? 2'b10 : resp;

        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);

        for (int k = 1; k <= 60 && !done; k++) begin
            if (k == rst_at) begin
                check("pre_reset_bready", m_bready, 1);
                rst_n = 1'b0;
                #1;
                check("reset_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
                check("reset_cmd_ready", cmd_ready, 1);
                clear_slave();
                rsp_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_reset_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
                return;
            end

            if (rsp_at < 0 && rsp_valid) begin
                rsp_at = k;
                check("rsp_latency", rsp_at, e_rsp);
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_resp", rsp_resp, e_resp);
                check("rsp_timeout", rsp_timeout, e_to);
                check("rsp_axi_quiet", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
            end

            if (rsp_at >= 0) begin
                if (k == rsp_at + hold + 1) begin
                    check("back_to_idle", {rsp_valid, cmd_ready}, 2'b01);
                    rsp_ready = 1'b0;
                    done = 1'b1;
                end else if (k >= rsp_at + hold) begin
                    rsp_ready = 1'b1;
                end else if (k > rsp_at) begin
                    check("rsp_hold_stable", {rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata},
                          {1'b1, 1'b0, e_to, e_resp, e_rdata});
                end
            end

            if (!done) begin
                // write address / data channels
                m_awready = m_awvalid && (awc >= aw_dly);
                if (m_awvalid) begin
                    if (m_awready) begin
                        aw_at = k;
                        check("awaddr", m_awaddr, addr);
                    end
                    awc++;
                end
                if (aw_at >= 0 && k == aw_at + 1) check("awvalid_drop", m_awvalid, 0);
                m_wready = m_wvalid && (wc >= w_dly);
                if (m_wvalid) begin
                    if (m_wready) begin
                        w_at = k;
                        check("wdata_wstrb", {m_wstrb, m_wdata}, {strb, wdata});
                    end
                    wc++;
                end
                if (w_at >= 0 && k == w_at + 1) check("wvalid_drop", m_wvalid, 0);
                // write response: held once raised, even if never accepted
                if (wr && aw_at >= 0 && w_at >= 0 && aw_at < k && w_at < k && b_at < 0) begin
                    m_bvalid = (bc >= rsp_dly);
                    m_bresp  = resp;
                    if (m_bvalid && m_bready) begin
                        b_at = k;
                        n_b++;
                    end
                    bc++;
                end else if (b_at >= 0) begin
                    m_bvalid = 1'b0;
                end
                // read address / data channels
                m_arready = m_arvalid && (arc >= ar_dly);
                if (m_arvalid) begin
                    if (m_arready) begin
                        ar_at = k;
                        check("araddr", m_araddr, addr);
                    end
                    arc++;
                end
                if (ar_at >= 0 && k == ar_at + 1) check("arvalid_drop", m_arvalid, 0);
                if (!wr && ar_at >= 0 && ar_at < k && r_at < 0) begin
                    m_rvalid = (rc >= rsp_dly);
                    m_rdata  = m_rvalid ? rdata : $urandom;
                    m_rresp  = resp;
                    if (m_rvalid && m_rready) begin
                        r_at = k;
                        n_r++;
                    end
                    rc++;
                end else if (r_at >= 0) begin
                    m_rvalid = 1'b0;
                end
                @(negedge clk);
            end
        end

        check("txn_done", done, 1);
        if (wr) begin
            check("b_accepted", n_b, e_to ? 0 : 1);
            if (!e_to) check("aw_w_cycle", {aw_at, w_at}, {e_aw, e_w});
        end else begin
            check("r_accepted", n_r, e_to ? 0 : 1);
        end
        clear_slave();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        clear_slave();
        #3;
        check("reset_cmd_ready0", cmd_ready, 1);
        check("reset_ctrl", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, rsp_timeout, rsp_resp}, 0);
        check("reset_payload", {rsp_rdata, m_awaddr}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait write
        run_txn(1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, -1);
        // awready three cycles ahead of wready
        run_txn(1, 32'h1000_0010, 32'h0BAD_F00D, 4'h3, 0, 3, 0, 0, 2'b00, 32'h0, 0, -1);
        // read with five stall cycles before R, DECERR
        run_txn(0, 32'h1000_0008, 32'h0, 4'h0, 0, 0, 0, 5, 2'b11, 32'h1234_5678, 0, -1);
        // arready stuck low -> timeout
        run_txn(0, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 1000, 0, 2'b00, 32'h0, 0, -1);
        // R handshake exactly on the last allowed cycle wins
        run_txn(0, 32'h2000_0004, 32'h0, 4'h0, 0, 0, 0, 13, 2'b01, 32'hCAFE_0001, 0, -1);
        // B one cycle too late -> timeout, late beat never accepted
        run_txn(1, 32'h2000_0008, 32'h1111_2222, 4'hC, 0, 0, 0, 14, 2'b00, 32'h0, 0, -1);
        // response held off for four cycles
        run_txn(1, 32'h3000_0000, 32'h5555_AAAA, 4'h5, 1, 0, 0, 1, 2'b10, 32'h0, 4, -1);
        // reset while waiting in WR_RESP, then a fresh write
        run_txn(1, 32'h4000_0000, 32'h7777_8888, 4'hF, 0, 0, 0, 8, 2'b00, 32'h0, 0, 4);
        run_txn(1, 32'h4000_0004, 32'h9999_AAAA, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, -1);

        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    2'($urandom), $urandom, int'($urandom_range(0, 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_simple2axi_master
